fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the architectural PC register and feeds it to the next-PC logic. It issues word requests to instruction memory over a variable-latency req/ack handshake and presents fetched instructions to the IF/ID boundary. It applies redirects (branch/jump targets computed in ID) and stalls from the hazard unit. It discards instructions already in flight when a redirect kills them.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
MAX_WAIT, 16, cycles a request may wait for ack before err_o sets; range 1..255

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
redirect_i  input  1  take redirect_pc_i as next fetch PC; highest priority
redirect_pc_i  input  32  redirect target; bits[1:0] forced to 0
stall_i  input  1  IF/ID cannot accept; hold output
imem_req_o  output  1  fetch request, held until ack
imem_addr_o  output  32  fetch word address; stable while imem_req_o=1
imem_ack_i  input  1  data valid this cycle; may arrive in the same cycle as req
imem_rdata_i  input  32  fetched word
if_valid_o  output  1  if_instr_o/if_pc_o are valid
if_instr_o  output  32  fetched instruction
if_pc_o  output  32  PC of if_instr_o
pc_o  output  32  current fetch PC, to next-PC logic as PC_Out
err_o  output  1  sticky: ack timeout occurred

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, imem_req_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, err_o=0, wait_cnt=0, target=0.
- States: IDLE, REQ, HOLD, DROP.
- IDLE: outputs idle.
  - Next cycle go to REQ.
  - A redirect in IDLE loads pc, then go to REQ.
- REQ: imem_req_o=1, imem_addr_o=pc.
  - ack, no redirect, no stall: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, stay REQ. Sustains 1 instr/cycle with zero-wait memory.
  - ack, no redirect, stall=1 while if_valid=1: ack cannot occur here. A request is not issued while the output slot is full and stalled.
  - No ack: stay REQ, wait_cnt++.
- Output slot rule: if stall_i=1 and if_valid_o=1, the REQ→REQ reissue is suppressed. Instead go to HOLD with if_* frozen.
- HOLD: imem_req_o=0, if_* frozen.
  - stall_i=0: if_valid<=0, then REQ next cycle.
  - Or a same-cycle fast path: reissue so consumption and the new request overlap.
- When stall_i=0, if_valid_o drops the cycle after consumption unless a new ack refills it.
- Redirect priority over everything, including stall:
  - IDLE/HOLD: if_valid<=0, pc<=redirect_pc, go REQ.
  - REQ with same-cycle ack: data discarded, if_valid<=0, pc<=redirect_pc, stay REQ (new address next cycle).
  - REQ without ack: the in-flight request cannot be cancelled. target<=redirect_pc, if_valid<=0, go DROP.
- DROP: imem_req_o=1 on the old address.
  - On ack: data discarded, pc<=target, go REQ.
  - A redirect in DROP overwrites target (latest wins). If it coincides with ack, use the new redirect_pc.
- Timeout: wait_cnt counts cycles req=1 without ack. It clears on ack and on state change. Reaching MAX_WAIT sets err_o (sticky until reset). The request stays asserted.
- Arithmetic: pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0 with no flag.
- if_pc_o always equals the address that produced if_instr_o. pc_o is the registered pc.
- Reset mid-request: all state clears immediately. A late ack after release is ignored unless state is REQ or DROP.

Decomposition:
- Shared package mips_pkg:
  - RESET_PC default
  - fetch-state encoding (2-bit: IDLE=0, REQ=1, HOLD=2, DROP=3)
  - NOP word 32'h0000_0000
- One sub-module: fetch_wait_timer, an 8-bit saturating counter with clear/enable and a timeout flag compared against MAX_WAIT.

Test Plan:
- Reset release, zero-wait memory (ack same cycle): fetch addresses 0x3000, 0x3004, 0x3008 on consecutive cycles. if_pc_o follows one cycle later. if_valid_o=1 continuously.
- stall_i=1 for 3 cycles with if_valid_o=1, at if_pc=0x3004: if_instr/if_pc stay frozen and imem_req_o=0. Fetch resumes at 0x3008 after stall drops.
- 3-cycle-latency memory, redirect_i to 0x3100 one cycle after req to 0x3008: the 0x3008 data is discarded when it arrives and never appears with if_valid_o=1. The next request address is 0x3100.
- redirect_i to 0x3200 coincident with ack and stall_i=1: if_valid_o drops next cycle and the next request is 0x3200. Redirect wins over stall.
- Two redirects during DROP (0x3300, then 0x3400): only 0x3400 is fetched after the pending ack.
- No ack for MAX_WAIT=16 cycles: err_o rises at cycle 16 and stays high after the late ack. Normal fetch continues. redirect_pc_i=0x3103 is fetched as 0x3100.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
//
// Purpose: holds the reset PC default, the 2-bit fetch-state encoding and
// the NOP word used to clear the IF/ID instruction register, plus a small
// word-alignment helper shared by the fetch sequencer.
// Ports: none (package).
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

  // Instruction fetches are always whole words; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory req/ack handshake bundle
//
// Purpose: groups the word-fetch handshake between the fetch sequencer
// (master) and instruction memory (slave).
// Signals:
//   req   - fetch request, held by the master until ack
//   addr  - word address, stable while req=1
//   ack   - memory returns rdata this cycle (may coincide with first req cycle)
//   rdata - fetched instruction word
interface fetch_ctrl_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - saturating ack-wait counter with timeout flag
//
// Purpose: counts cycles an instruction-memory request waits for ack.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr_i      - clear the count (wins over en_i)
//   en_i       - one more waiting cycle this clock
//   expire_o   - this waiting cycle brings the count to MAX_WAIT
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // expire_o looks one count ahead so the sticky error sets on the same
  // edge at which the count reaches MAX_WAIT.
  localparam logic [7:0] LAST_BEFORE_LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q >= LAST_BEFORE_LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer owning the PC register
//
// Purpose: issues word fetches over a variable-latency req/ack handshake,
// presents fetched instructions to IF/ID, applies redirects and stalls, and
// discards in-flight data killed by a redirect.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   redirect_i     - load redirect_pc_i as next fetch PC (highest priority)
//   redirect_pc_i  - redirect target, low two bits ignored
//   stall_i        - IF/ID cannot accept; hold the output slot
//   imem           - instruction-memory handshake (master side)
//   if_valid_o     - if_instr_o / if_pc_o carry a valid instruction
//   if_instr_o     - fetched instruction
//   if_pc_o        - address that produced if_instr_o
//   pc_o           - registered fetch PC, to the next-PC logic
//   err_o          - sticky ack-timeout flag
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic               stall_i,
  fetch_ctrl_if.master       imem,
  output logic               if_valid_o,
  output logic [31:0]        if_instr_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        pc_o,
  output logic               err_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         err_q, err_d;

  logic         slot_blocked;
  logic         req_w;
  logic         ack_w;
  logic [31:0]  redir_pc;
  logic         tmr_clr;
  logic         tmr_en;
  logic         tmr_expire;

  assign redir_pc = word_align(redirect_pc_i);

  // A full, stalled output slot has nowhere to put new data, so no request
  // goes out. This can only be true on the first cycle of a request: a
  // request that keeps waiting with stall_i=0 empties the slot first.
  assign slot_blocked = stall_i && if_valid_q;

  always_comb begin
    req_w = 1'b0;
    case (state_q)
      FETCH_REQ:  req_w = !slot_blocked;
      FETCH_DROP: req_w = 1'b1;
      FETCH_IDLE: req_w = 1'b0;
      FETCH_HOLD: req_w = 1'b0;
    endcase
  end

  // An ack without an outstanding request is ignored (e.g. a late ack
  // arriving just after reset release).
  assign ack_w = req_w && imem.ack;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    case (state_q)
      FETCH_IDLE: begin
        if (redirect_i) begin
          pc_d = redir_pc;
        end
        state_d = FETCH_REQ;
      end

      FETCH_REQ: begin
        if (redirect_i) begin
          if_valid_d = 1'b0;
          if (req_w && !ack_w) begin
            // The request already on the bus cannot be withdrawn; park the
            // target and swallow the stale data when it shows up.
            target_d = redir_pc;
            state_d  = FETCH_DROP;
          end else begin
            pc_d = redir_pc;
          end
        end else if (slot_blocked) begin
          state_d = FETCH_HOLD;
        end else if (ack_w) begin
          if_instr_d = imem.rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_STEP;
        end else begin
          // Slot was consumed (stall_i=0) or already empty.
          if_valid_d = 1'b0;
        end
      end

      FETCH_HOLD: begin
        if (redirect_i) begin
          if_valid_d = 1'b0;
          pc_d       = redir_pc;
          state_d    = FETCH_REQ;
        end else if (!stall_i) begin
          if_valid_d = 1'b0;
          state_d    = FETCH_REQ;
        end
      end

      FETCH_DROP: begin
        if (ack_w) begin
          // A redirect landing on the ack cycle is newer than target_q.
          pc_d    = redirect_i ? redir_pc : target_q;
          state_d = FETCH_REQ;
        end else if (redirect_i) begin
          target_d = redir_pc;
        end
      end
    endcase
  end

  assign tmr_en  = req_w && !ack_w;
  assign tmr_clr = ack_w || (state_d != state_q);
  assign err_d   = err_q || tmr_expire;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      target_q   <= 32'd0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_WORD;
      if_pc_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      err_q      <= err_d;
    end
  end

  assign imem.req   = req_w;
  assign imem.addr  = pc_q;
  assign if_valid_o = if_valid_q;
  assign if_instr_o = if_instr_q;
  assign if_pc_o    = if_pc_q;
  assign pc_o       = pc_q;
  assign err_o      = err_q;

endmodule
